// File: rtl/pc_unit.sv
// Program counter unit: holds the fetch PC, selects the next PC from
// trap / stall / jalr / branch / sequential sources, rejects misaligned
// control-flow targets by redirecting to the trap vector, and sequences
// a small BOOT -> RUN <-> HALT state machine.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
   parameter int              INC          = 4,
   parameter int              ALIGN_C      = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jalr,
   input  logic [XLEN-1:0] jalr_base,
   input  logic [XLEN-1:0] jalr_off,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            halt,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic            fetch_valid,
   output logic            misalign,
   output logic [1:0]      state
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [XLEN-1:0] INC_V       = XLEN'(INC);
   localparam logic            CHECK_ALIGN = (ALIGN_C == 0);

   state_t          state_reg;
   logic [XLEN-1:0] pc_reg;
   logic            misalign_reg;

   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_tgt;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] tvec;
   logic            jalr_bad;
   logic            br_bad;

   // Candidate targets: bit 0 is never part of an instruction address,
   // and the trap vector is always word aligned.
   assign jalr_sum = jalr_base + jalr_off;
   assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
   assign br_tgt   = {br_target[XLEN-1:1], 1'b0};
   assign tvec     = {trap_vec[XLEN-1:2], 2'b00};
   assign jalr_bad = CHECK_ALIGN & jalr_tgt[1];
   assign br_bad   = CHECK_ALIGN & br_tgt[1];

   assign pc          = pc_reg;
   assign pc_plus     = pc_reg + INC_V;
   assign misalign    = misalign_reg;
   assign state       = state_reg;
   assign fetch_valid = (state_reg == RUN);

   // State machine and PC register; misalign is a one-cycle registered pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= BOOT;
         pc_reg       <= RESET_VECTOR;
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= 1'b0;
         case (state_reg)
            BOOT: begin
               state_reg <= RUN;
            end
            RUN: begin
               if (trap) begin
                  pc_reg <= tvec;
               end else if (!stall) begin
                  if (jalr) begin
                     if (jalr_bad) begin
                        pc_reg       <= tvec;
                        misalign_reg <= 1'b1;
                     end else begin
                        pc_reg <= jalr_tgt;
                     end
                  end else if (br_taken) begin
                     if (br_bad) begin
                        pc_reg       <= tvec;
                        misalign_reg <= 1'b1;
                     end else begin
                        pc_reg <= br_tgt;
                     end
                  end else begin
                     pc_reg <= pc_plus;
                  end
               end
               if (halt && !trap) begin
                  state_reg <= HALT;
               end
            end
            HALT: begin
               if (trap) begin
                  pc_reg    <= tvec;
                  state_reg <= RUN;
               end else if (resume) begin
                  state_reg <= RUN;
               end
            end
            default: begin
               state_reg <= BOOT;
               pc_reg    <= RESET_VECTOR;
            end
         endcase
      end
   end

endmodule
